// File: rtl/i2si_bist_pkg.sv
// Shared types and helpers for the I2S-input BIST controller.
package i2si_bist_pkg;

    localparam int VAL_W = 12;
    localparam int INC_W = 8;
    localparam int CNT_W = 16;

    localparam int STS_CFG_ERR   = 0;
    localparam int STS_LOCK_FAIL = 1;
    localparam int STS_TMO       = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_ARM,
        ST_SYNC,
        ST_RUN,
        ST_DONE
    } state_e;

    // Next ramp value; the sum is kept one bit wider so a large increment is never truncated.
    function automatic logic [VAL_W-1:0] ramp_next(input logic [VAL_W-1:0] cur,
                                                   input logic [INC_W-1:0] inc,
                                                   input logic [VAL_W-1:0] start_val,
                                                   input logic [VAL_W-1:0] up_limit);
        logic [VAL_W:0] sum;
        sum = {1'b0, cur} + {{(VAL_W+1-INC_W){1'b0}}, inc};
        if (sum > {1'b0, up_limit})
            return start_val;
        return sum[VAL_W-1:0];
    endfunction

endpackage

// File: rtl/i2si_bist_ref_model.sv
// Expected-sample register for the BIST ramp: load to start value, step with wrap.
module i2si_bist_ref_model
    import i2si_bist_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [VAL_W-1:0] start_val_i,
    input  logic [INC_W-1:0] inc_i,
    input  logic [VAL_W-1:0] up_limit_i,
    output logic [VAL_W-1:0] exp_o
);

    logic [VAL_W-1:0] exp_q, exp_d;

    always_comb begin
        exp_d = exp_q;
        if (load_i)
            exp_d = start_val_i;
        else if (step_i)
            exp_d = ramp_next(exp_q, inc_i, start_val_i, up_limit_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            exp_q <= '0;
        else
            exp_q <= exp_d;
    end

    assign exp_o = exp_q;

endmodule

// File: rtl/i2si_bist_ctrl.sv
// I2S-input BIST session sequencer. Optional rx watchdog: I2SI_BIST_TIMEOUT_EN.
//   state   | meaning
//   IDLE    | no session, generator held clear
//   CFG     | sample and validate rf_bist_* config
//   ARM     | generator held at start value for ARM_CYC clocks
//   SYNC    | hunt for first sample equal to start value
//   RUN     | compare num_smp samples against the ramp model
//   DONE    | result reported, waiting for next start
module i2si_bist_ctrl
    import i2si_bist_pkg::*;
#(
    parameter int unsigned ARM_CYC    = 4,
    parameter int unsigned SYNC_LIMIT = 64
`ifdef I2SI_BIST_TIMEOUT_EN
    ,
    parameter int unsigned TMO_CYC    = 4096
`endif
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             rf_bist_start_i,
    input  logic             rf_bist_abort_i,
    input  logic [VAL_W-1:0] rf_bist_start_val_i,
    input  logic [INC_W-1:0] rf_bist_inc_i,
    input  logic [VAL_W-1:0] rf_bist_up_limit_i,
    input  logic [CNT_W-1:0] rf_bist_num_smp_i,
    output logic             gen_clr_o,
    output logic             i2si_bist_sel_o,
    input  logic             rx_vld_i,
    input  logic [31:0]      rx_data_i,
    output logic             bist_busy_o,
    output logic             bist_done_o,
    output logic             bist_pass_o,
    output logic [2:0]       bist_status_o,
    output logic [CNT_W-1:0] bist_err_cnt_o,
    output logic [31:0]      bist_first_err_o
);

    localparam int ARM_W  = $clog2(ARM_CYC + 1);
    localparam int SYNC_W = $clog2(SYNC_LIMIT + 1);

    state_e           state_q, state_d;
    logic [VAL_W-1:0] start_q, start_d, lim_q, lim_d;
    logic [INC_W-1:0] inc_q, inc_d;
    logic [CNT_W-1:0] num_q, num_d, rem_q, rem_d;
    logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic [2:0]       status_q, status_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [31:0]      first_err_q, first_err_d;
    logic             done_q, done_d, pass_q, pass_d;
    logic [VAL_W-1:0] exp_val;
    logic             match, cfg_err, ref_load, ref_step;

`ifdef I2SI_BIST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    assign match   = (rx_data_i[27:16] == exp_val) && (rx_data_i[11:0] == exp_val);
    assign cfg_err = (rf_bist_inc_i == '0) || (rf_bist_start_val_i > rf_bist_up_limit_i)
                     || (rf_bist_num_smp_i == '0);

    always_comb begin
        state_d     = state_q;
        start_d     = start_q;
        lim_d       = lim_q;
        inc_d       = inc_q;
        num_d       = num_q;
        rem_d       = rem_q;
        arm_cnt_d   = arm_cnt_q;
        sync_cnt_d  = sync_cnt_q;
        status_d    = status_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        done_d      = done_q;
        pass_d      = pass_q;
        ref_load    = 1'b0;
        ref_step    = 1'b0;
`ifdef I2SI_BIST_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (rf_bist_start_i && !rf_bist_abort_i) begin
                    state_d = ST_CFG;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            ST_CFG: begin
                start_d = rf_bist_start_val_i;
                lim_d   = rf_bist_up_limit_i;
                inc_d   = rf_bist_inc_i;
                num_d   = rf_bist_num_smp_i;
                if (cfg_err) begin
                    status_d = 3'b000;
                    status_d[STS_CFG_ERR] = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    status_d    = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    arm_cnt_d   = ARM_W'(ARM_CYC - 1);
                    state_d     = ST_ARM;
                end
            end
            ST_ARM: begin
                ref_load   = 1'b1;
                sync_cnt_d = SYNC_W'(SYNC_LIMIT - 1);
`ifdef I2SI_BIST_TIMEOUT_EN
                tmo_cnt_d  = TMO_W'(TMO_CYC - 1);
`endif
                if (arm_cnt_q == '0)
                    state_d = ST_SYNC;
                else
                    arm_cnt_d = arm_cnt_q - 1'b1;
            end
            ST_SYNC: begin
                if (rx_vld_i) begin
                    if (match) begin
                        ref_step = 1'b1;
                        rem_d    = num_q - 1'b1;
                        state_d  = (num_q == CNT_W'(1)) ? ST_DONE : ST_RUN;
                    end else if (sync_cnt_q == '0) begin
                        status_d[STS_LOCK_FAIL] = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        sync_cnt_d = sync_cnt_q - 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (rx_vld_i) begin
                    ref_step = 1'b1;
                    if (!match) begin
                        if (err_cnt_q == '0)
                            first_err_d = rx_data_i;
                        if (err_cnt_q != '1)
                            err_cnt_d = err_cnt_q + 1'b1;
                    end
                    if (rem_q == CNT_W'(1))
                        state_d = ST_DONE;
                    else
                        rem_d = rem_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef I2SI_BIST_TIMEOUT_EN
        // Watchdog reloads on every strobe; a silent rx path for TMO_CYC clocks ends the session.
        if ((state_q == ST_SYNC || state_q == ST_RUN) && state_d == state_q) begin
            if (rx_vld_i) begin
                tmo_cnt_d = TMO_W'(TMO_CYC - 1);
            end else if (tmo_cnt_q == '0) begin
                status_d[STS_TMO] = 1'b1;
                state_d = ST_DONE;
            end else begin
                tmo_cnt_d = tmo_cnt_q - 1'b1;
            end
        end
`endif

        if (rf_bist_abort_i && state_q != ST_IDLE && state_q != ST_DONE)
            state_d = ST_IDLE;

        if (state_d == ST_DONE && state_q != ST_DONE) begin
            done_d = 1'b1;
            pass_d = (err_cnt_d == '0) && (status_d == '0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            start_q     <= '0;
            lim_q       <= '0;
            inc_q       <= '0;
            num_q       <= '0;
            rem_q       <= '0;
            arm_cnt_q   <= '0;
            sync_cnt_q  <= '0;
            status_q    <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            lim_q       <= lim_d;
            inc_q       <= inc_d;
            num_q       <= num_d;
            rem_q       <= rem_d;
            arm_cnt_q   <= arm_cnt_d;
            sync_cnt_q  <= sync_cnt_d;
            status_q    <= status_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
        end
    end

`ifdef I2SI_BIST_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            tmo_cnt_q <= '0;
        else
            tmo_cnt_q <= tmo_cnt_d;
    end
`endif

    i2si_bist_ref_model u_ref (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .load_i      (ref_load),
        .step_i      (ref_step),
        .start_val_i (start_q),
        .inc_i       (inc_q),
        .up_limit_i  (lim_q),
        .exp_o       (exp_val)
    );

    assign bist_busy_o      = (state_q == ST_ARM) || (state_q == ST_SYNC) || (state_q == ST_RUN);
    assign i2si_bist_sel_o  = bist_busy_o;
    assign gen_clr_o        = !((state_q == ST_SYNC) || (state_q == ST_RUN));
    assign bist_done_o      = done_q;
    assign bist_pass_o      = pass_q;
    assign bist_status_o    = status_q;
    assign bist_err_cnt_o   = err_cnt_q;
    assign bist_first_err_o = first_err_q;

endmodule
